uart_rx: RTL
============

Name: uart_rx

Overview:
Serial receiver paired with the existing transmitter. It accepts an asynchronous 8N1 line (idle high, start 0, 8 data bits LSB first, stop 1) and synchronises it into the clk domain. It reassembles each byte and presents it on a valid/ready byte interface to the processor's MMIO/peripheral logic. The default bit timing matches the transmitter: 50 MHz clk, 9600 baud.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per serial bit (50e6/9600); must be >= 8
CNT_W, $clog2(CLKS_PER_BIT), bit-period counter width (derived, do not override)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial line; idles high
rx_data  output  8  last received byte; stable while rx_valid=1
rx_valid  output  1  byte available; held until consumed
rx_ready  input  1  consumer accepts the byte in any cycle where rx_valid && rx_ready
frame_err  output  1  one-cycle pulse when the stop bit is sampled 0
overrun  output  1  one-cycle pulse when a new byte overwrites an unconsumed byte

Behaviour:
- Synchroniser: rxd passes through a 2-flop synchroniser; rxd_s is the result. Both flops reset to 1. All logic below uses only rxd_s.
- Counters: bit-period counter cnt (CNT_W bits) and bit index bidx (3 bits). HALF = CLKS_PER_BIT/2, using integer division.
- The sample value "s" is rxd_s in the sample cycle.
- IDLE: cnt=0. When rxd_s==0, go to START.
- START: cnt increments each cycle. When cnt==HALF-1:
  - s==0: go to DATA with cnt=0, bidx=0.
  - s==1: glitch; return to IDLE with no output.
- DATA: cnt increments each cycle. When cnt==CLKS_PER_BIT-1:
  - shift s in at the MSB of shift register sr (sr <= {s, sr[7:1]}); cnt=0; bidx++.
  - After the sample taken with bidx==7, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1:
  - s==1: rx_data<=sr, rx_valid<=1, go to IDLE. The sample lands mid-stop-bit, leaving half a bit of margin for the next start edge.
  - s==0: frame_err pulses for 1 cycle, sr is discarded, rx_valid is unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxd_s==1, then go to IDLE. A held-low line (break) therefore never produces bytes.
- Consume: rx_valid && rx_ready clears rx_valid on the next edge.
- Simultaneous consume and new byte: the new byte is loaded, rx_valid stays 1, no overrun.
- Overrun: a new byte completes while rx_valid==1 and rx_ready==0. rx_data is overwritten with the new byte, rx_valid stays 1, overrun pulses for 1 cycle.
- Latency: rx_valid rises the cycle after the stop-bit sample. That is about 2 (sync) + 1 + HALF + 9*CLKS_PER_BIT cycles after the rxd falling edge.
- Reset, including mid-frame:
  - state=IDLE, cnt=0, bidx=0, sr=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, synchroniser=1.
  - The partial frame is discarded.
  - If the line is low when reset releases, START is entered and the glitch check applies.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined:
  - A 3-bit history register h holds the last three rxd_s values. It resets to 3'b111 and shifts every cycle.
  - s = majority(h) at every sample point: START confirm, DATA bits and STOP.
  - The IDLE start detect still uses raw rxd_s==0.
  - Requires CLKS_PER_BIT >= 8.
- Undefined: s = rxd_s. No history register is instantiated.

Decomposition:
- Package uart_pkg:
  - UART_DATA_BITS=8
  - UART_DEFAULT_CLKS_PER_BIT=5208
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
- The transmitter's baud constant migrates to the package later.
- One sub-module: sync_2ff, a 1-bit 2-flop synchroniser with a reset value parameter. It is reusable for other async inputs.

Test Plan:
- Run benches with CLKS_PER_BIT=16 unless stated otherwise.
- Single byte: drive frame for 8'hA5 at exact bit timing, rx_ready=1 -> rx_data=8'hA5, rx_valid high exactly 1 cycle, frame_err=0, overrun=0.
- Back-to-back: frames 8'h00, 8'hFF, 8'h55 with no idle gap, rx_ready=1 -> three valids in order with the correct bytes.
- Glitch: rxd low for 3 cycles (< HALF), then high -> no rx_valid; FSM returns to IDLE; a following 8'h3C frame is received correctly.
- Framing error: frame 8'h81 with stop bit 0, line then low for 40 cycles -> frame_err pulses once, rx_valid stays 0, no further bytes until the line returns high; the next 8'h12 frame is received.
- Overrun and simultaneous events:
  - rx_ready=0, send 8'h11 then 8'h22 -> overrun pulses once, rx_data=8'h22, rx_valid=1.
  - rx_ready asserted in the exact cycle a new byte lands -> no overrun.
- Reset mid-frame and loopback:
  - Assert reset during bit 4 -> all outputs at reset values; the next full frame decodes correctly.
  - Loopback with the transmitter at default CLKS_PER_BIT=5208, sending 8'hC3 -> rx_data=8'hC3.
  - Repeat the loopback with UART_RX_MAJORITY_EN defined, injecting 1-cycle glitches at sample points -> bytes unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path (and the transmitter once its baud constant migrates here).
// Latency: none; declarations and one combinational helper only.
// Backpressure: not applicable.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // 2-of-3 vote, used to reject single-cycle line glitches at sample points
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input; reset value is selectable.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver presenting bytes on a valid/ready interface; build with UART_RX_MAJORITY_EN for 2-of-3 sample voting.
// Latency: rx_valid rises about 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rxd falling edge.
// Backpressure: one-byte holding register; a new byte overwrites an unconsumed one and pulses overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  // Start confirmation lands half a bit in; every later sample is one full bit apart
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                      rxd_s;
  logic                      s;
  uart_rx_state_t            state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bidx;
  logic [UART_DATA_BITS-1:0] sr;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxd),
    .q    (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] h;

  // Rolling history of the last three synchronised line values
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= 3'b111;
    end else begin
      h <= {h[1:0], rxd_s};
    end
  end

  assign s = maj3(h);
`else
  assign s = rxd_s;
`endif

  // Frame FSM: detect start, sample mid-bit, assemble byte and hand it off
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      sr        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer handshake; a byte landing this same cycle re-asserts below
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          // Raw edge detect; the glitch filter is the half-bit confirm in START
          if (!rxd_s) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt  <= '0;
            bidx <= '0;
            state <= s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            // LSB arrives first, so shift in from the top
            sr   <= {s, sr[UART_DATA_BITS-1:1]};
            cnt  <= '0;
            bidx <= bidx + 3'd1;
            if (bidx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (s) begin
              rx_data  <= sr;
              rx_valid <= 1'b1;
              // Simultaneous consume frees the slot, so that case is not an overrun
              overrun  <= rx_valid && !rx_ready;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              sr        <= '0;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) parks here so it cannot decode as 0x00 bytes
          if (rxd_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
